cnt_checker: RTL and testbench
==============================

# cnt_checker

Self-checking monitor for the 4-bit `util` up-counter: observes the counter's init strobe and count bus, predicts the next value, and flags and counts deviations. It sits beside the counter in the test harness as the consuming end of its `init`/`cnt` interface, replacing hand-inspected waveforms with pass/fail status. Synthesizable, so it can also serve as an on-chip sequence watchdog.

## Interface
Parameters:
- `WIDTH`, 4: width of the observed count bus.
- `STEP`, 1: expected increment per clock, modulo 2^WIDTH.
- `INIT_VAL`, 0: count value the counter holds after its init strobe.
- `LOCK_N`, 2: number of consecutive correct samples needed to leave LOST; must be at least 1.
- `ERR_W`, 8: width of the error counter.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `init_n`, in, 1: reset, synchronous, active-low.
- `cnt_init`, in, 1: the counter's init strobe, active-high, sampled synchronously.
- `cnt_in`, in, WIDTH: the counter's output.
- `err_clr`, in, 1: clears `err_count` and `sticky_err`.
- `locked`, out, 1: high when the checker is in TRACK.
- `mismatch`, out, 1: one-cycle pulse per loss event.
- `sticky_err`, out, 1: set on any mismatch.
- `err_count`, out, ERR_W: count of loss events, saturating.
- `wrap_count`, out, 8: count of wraps of the tracked value, modulo 256.
- `exp_cnt`, out, WIDTH: the current predicted value.

## Operation
- States: IDLE, ARM, TRACK, LOST. The state register is 2 bits.
- `locked` is decoded from the state register (state == TRACK).
- `init_n` = 0 at an edge:
  - state goes to IDLE, `exp_cnt` = INIT_VAL, `good_run` = 0.
  - All other outputs are 0.
  - This has priority over every other input.
- `cnt_init` = 1 at an edge, in any state:
  - state goes to ARM, `exp_cnt` = INIT_VAL, `good_run` = 0, `mismatch` = 0.
  - No comparison is made; `cnt_in` is ignored that cycle.
- IDLE: `cnt_in` is ignored; the checker waits for `cnt_init`.
- ARM or TRACK, with `cnt_init` = 0:
  - Match (`cnt_in == exp_cnt`): `exp_cnt` <= `exp_cnt` + STEP (truncated to WIDTH); state goes to TRACK.
  - Mismatch:
    - `mismatch` <= 1 and `sticky_err` <= 1.
    - `err_count` <= `err_count` + 1, saturating at 2^ERR_W − 1.
    - `exp_cnt` <= `cnt_in` + STEP; `good_run` <= 0; state goes to LOST.
- LOST, with `cnt_init` = 0:
  - Match: `good_run` increments and `exp_cnt` += STEP. When `good_run` reaches LOCK_N − 1 on a match, state goes to TRACK and `good_run` clears.
  - Mismatch: `exp_cnt` <= `cnt_in` + STEP and `good_run` <= 0. There is no new `mismatch` pulse and `err_count` does not change: one loss event is counted once.
- Wrap counting: `wrap_count` increments on a matching sample in ARM or TRACK when `exp_cnt` + STEP carries out of WIDTH bits. It is not counted in LOST.
- `mismatch` returns to 0 on the next edge unless a new loss event occurs.
- `err_clr` = 1:
  - `err_count` and `sticky_err` clear.
  - If a loss event happens in the same edge, the mismatch wins: `err_count` = 1, `sticky_err` = 1.
- All arithmetic is unsigned and modulo the register width.

## Timing
- Every output is registered. The only combinational path is `locked`, decoded from the state register.
- Latency:
  - A sample captured at edge k drives `mismatch`, `err_count` and `locked` during cycle k+1.
  - From `cnt_init` to `locked`: one cycle in ARM, then `locked` rises after the first matching sample.
  - From a mismatch to `locked` again: LOCK_N consecutive matching samples.
- `cnt_in` must be stable around the rising edge. It is driven by the counter's register on the same clock.
- Simultaneous events at one edge, highest priority first: `init_n` low, then `cnt_init`, then the compare.

## Test plan
All scenarios use WIDTH=4, STEP=1, INIT_VAL=0, LOCK_N=2.
- Pulse `init_n` low for 1 cycle; pulse `cnt_init`; drive `cnt_in` 0,1,…,15,0,…,15,0 → `locked` = 1 from the 2nd cycle after `cnt_init`; `mismatch` never asserts; `wrap_count` = 2; `err_count` = 0.
- In TRACK with `exp_cnt` = 3, drive `cnt_in` = 5, then 6, 7 → `mismatch` high for exactly 1 cycle; `err_count` = 1; `sticky_err` = 1; `locked` = 0, returning to 1 in the cycle after the sample of 7.
- With ERR_W=2, cause 5 separate loss events, each followed by relock → `err_count` saturates at 3; `mismatch` pulses 5 times. Then a lone `err_clr` → `err_count` = 0, `sticky_err` = 0.
- Assert `err_clr` at the same edge as a loss event → `err_count` = 1, `sticky_err` = 1.
- Hold `init_n` low in mid-TRACK for 1 cycle → all outputs 0 and `exp_cnt` = 0. Then random `cnt_in` with no `cnt_init` → state stays IDLE; `mismatch` and `locked` stay 0.
- In LOST, assert `cnt_init` with `cnt_in` = 9, then drive 0,1 → no `mismatch` pulse and `err_count` unchanged; `locked` rises after the sample of 0.

Source files
------------

// File: rtl/cnt_checker.sv
// cnt_checker: tracks a WIDTH-bit up-counter and predicts each next value.
// It flags every loss of sequence once and counts those events and the wraps.
module cnt_checker #(
    parameter int WIDTH    = 4,
    parameter int STEP     = 1,
    parameter int INIT_VAL = 0,
    parameter int LOCK_N   = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             cnt_init,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             mismatch,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       wrap_count,
    output logic [WIDTH-1:0] exp_cnt
);
    localparam int GW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);
    localparam logic [GW-1:0]    LAST_G = GW'(LOCK_N - 1);
    typedef enum logic [1:0] {IDLE, ARM, TRACK, LOST} state_t;
    state_t state;
    logic [GW-1:0] good_run;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] resync;
    logic hit, loss;
    assign sum    = {1'b0, exp_cnt} + {1'b0, STEP_W};
    assign resync = cnt_in + STEP_W;
    assign hit    = cnt_in == exp_cnt;
    assign loss   = !cnt_init && (state == ARM || state == TRACK) && !hit;
    assign locked = state == TRACK;
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state      <= IDLE;
            exp_cnt    <= INIT_W;
            good_run   <= '0;
            mismatch   <= 1'b0;
            sticky_err <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            mismatch <= loss;
            // A loss event on the same edge as a clear leaves a fresh count of one.
            if (loss) begin
                sticky_err <= 1'b1;
                err_count  <= err_clr ? ERR_W'(1) : (&err_count ? err_count : err_count + ERR_W'(1));
            end else if (err_clr) begin
                sticky_err <= 1'b0;
                err_count  <= '0;
            end
            if (cnt_init) begin
                state    <= ARM;
                exp_cnt  <= INIT_W;
                good_run <= '0;
            end else if (state == ARM || state == TRACK) begin
                exp_cnt    <= hit ? sum[WIDTH-1:0] : resync;
                state      <= hit ? TRACK : LOST;
                good_run   <= '0;
                wrap_count <= (hit && sum[WIDTH]) ? wrap_count + 8'd1 : wrap_count;
            end else if (state == LOST) begin
                exp_cnt  <= hit ? sum[WIDTH-1:0] : resync;
                state    <= (hit && good_run == LAST_G) ? TRACK : LOST;
                good_run <= (hit && good_run != LAST_G) ? good_run + GW'(1) : '0;
            end
        end
    end
endmodule

// File: tb/tb_cnt_checker.sv
// tb_cnt_checker: directed scoreboard bench for cnt_checker (WIDTH=4, STEP=1, LOCK_N=2).
module tb_cnt_checker;
    logic clk = 1'b0;
    logic init_n = 1'b0, cnt_init = 1'b0, err_clr = 1'b0;
    logic [3:0] cnt_in = '0;
    logic locked, mismatch, sticky_err;
    logic [7:0] err_count, wrap_count;
    logic [3:0] exp_cnt;
    logic s_locked, s_mismatch, s_sticky;
    logic [1:0] s_err;
    logic [7:0] s_wrap;
    logic [3:0] s_exp;
    int checks = 0, errors = 0, mis_seen = 0, step_no = 0;
    typedef struct packed {
        logic locked, mismatch, sticky;
        logic [7:0] err;
        logic [1:0] err2;
        logic [7:0] wrap;
        logic [3:0] exp;
    } obs_t;
    obs_t sb[$];
    int m_st = 0, m_exp = 0, m_good = 0, m_err = 0, m_err2 = 0, m_wrap = 0;
    bit m_mis = 0, m_sticky = 0;

    always #5 clk = ~clk;

    cnt_checker dut (
        .clk(clk), .init_n(init_n), .cnt_init(cnt_init), .cnt_in(cnt_in), .err_clr(err_clr),
        .locked(locked), .mismatch(mismatch), .sticky_err(sticky_err),
        .err_count(err_count), .wrap_count(wrap_count), .exp_cnt(exp_cnt)
    );
    cnt_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .init_n(init_n), .cnt_init(cnt_init), .cnt_in(cnt_in), .err_clr(err_clr),
        .locked(s_locked), .mismatch(s_mismatch), .sticky_err(s_sticky),
        .err_count(s_err), .wrap_count(s_wrap), .exp_cnt(s_exp)
    );

    // Reference behaviour: 0 IDLE, 1 ARM, 2 TRACK, 3 LOST.
    task automatic model(input bit in_n, input bit ci, input bit clr, input int v);
        bit loss;
        if (!in_n) begin
            m_st = 0; m_exp = 0; m_good = 0; m_err = 0; m_err2 = 0; m_wrap = 0;
            m_mis = 0; m_sticky = 0;
            return;
        end
        loss = !ci && (m_st == 1 || m_st == 2) && v != m_exp;
        m_mis = loss;
        if (loss) begin
            m_sticky = 1;
            m_err  = clr ? 1 : (m_err < 255 ? m_err + 1 : 255);
            m_err2 = clr ? 1 : (m_err2 < 3 ? m_err2 + 1 : 3);
        end else if (clr) begin
            m_sticky = 0; m_err = 0; m_err2 = 0;
        end
        if (ci) begin
            m_st = 1; m_exp = 0; m_good = 0;
        end else if (m_st == 1 || m_st == 2) begin
            if (loss) begin
                m_exp = (v + 1) % 16; m_good = 0; m_st = 3;
            end else begin
                if (m_exp == 15) m_wrap = (m_wrap + 1) % 256;
                m_exp = (m_exp + 1) % 16; m_st = 2;
            end
        end else if (m_st == 3) begin
            if (v == m_exp) begin
                m_exp = (m_exp + 1) % 16;
                if (m_good == 1) begin m_st = 2; m_good = 0; end
                else m_good = m_good + 1;
            end else begin
                m_exp = (v + 1) % 16; m_good = 0;
            end
        end
    endtask

    task automatic step(input bit in_n, input bit ci, input bit clr, input int v);
        obs_t e, o;
        init_n = in_n; cnt_init = ci; err_clr = clr; cnt_in = v[3:0];
        model(in_n, ci, clr, v);
        sb.push_back({(m_st == 2) ? 1'b1 : 1'b0, m_mis, m_sticky, 8'(m_err), 2'(m_err2), 8'(m_wrap), 4'(m_exp)});
        @(posedge clk);
        #1;
        step_no++;
        if (mismatch === 1'b1) mis_seen++;
        e = sb.pop_front();
        o = {locked, mismatch, sticky_err, err_count, s_err, wrap_count, exp_cnt};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL step%0d observed=%h expected=%h", step_no, o, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    initial begin
        int base;
        step(0, 0, 0, 0);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_exp", 32'(exp_cnt), 0);
        step(1, 1, 0, 0);
        chk("arm_not_locked", 32'(locked), 0);
        mis_seen = 0;
        for (int i = 0; i < 33; i++) begin
            step(1, 0, 0, i % 16);
            if (i == 0) chk("lock_after_first", 32'(locked), 1);
        end
        chk("run_wraps", 32'(wrap_count), 2);
        chk("run_no_mismatch", 32'(mis_seen), 0);
        chk("run_err", 32'(err_count), 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        chk("exp_three", 32'(exp_cnt), 3);
        step(1, 0, 0, 5);
        chk("loss_pulse", 32'(mismatch), 1);
        chk("loss_err", 32'(err_count), 1);
        chk("loss_sticky", 32'(sticky_err), 1);
        chk("loss_unlocked", 32'(locked), 0);
        step(1, 0, 0, 6);
        chk("pulse_one_cycle", 32'(mismatch), 0);
        chk("still_lost", 32'(locked), 0);
        step(1, 0, 0, 7);
        chk("relocked", 32'(locked), 1);
        step(1, 0, 1, 0);
        chk("clr_vs_loss_err", 32'(err_count), 1);
        chk("clr_vs_loss_sticky", 32'(sticky_err), 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 2);
        mis_seen = 0;
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, (m_exp + 7) % 16);
            step(1, 0, 0, m_exp);
            step(1, 0, 0, m_exp);
        end
        chk("sat_pulses", 32'(mis_seen), 5);
        chk("sat_err2", 32'(s_err), 3);
        chk("sat_err8", 32'(err_count), 6);
        step(1, 0, 1, m_exp);
        chk("clr_err", 32'(err_count), 0);
        chk("clr_sticky", 32'(sticky_err), 0);
        step(1, 0, 0, m_exp);
        step(0, 0, 0, m_exp);
        chk("midreset_exp", 32'(exp_cnt), 0);
        chk("midreset_wrap", 32'(wrap_count), 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, int'($urandom_range(0, 15)));
            chk("idle_locked", 32'(locked), 0);
            chk("idle_mismatch", 32'(mismatch), 0);
        end
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 9);
        base = int'(err_count);
        step(1, 1, 0, 9);
        chk("lost_init_no_pulse", 32'(mismatch), 0);
        step(1, 0, 0, 0);
        chk("lost_init_locked", 32'(locked), 1);
        chk("lost_init_no_pulse2", 32'(mismatch), 0);
        step(1, 0, 0, 1);
        chk("lost_init_err", 32'(err_count), 32'(base));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
